// File: rtl/pwm_multi_if.sv
// pwm_multi_if: valid/ready duty-write channel into the PWM generator
interface pwm_multi_if #(
    parameter int CHW       = 2,
    parameter int CNT_WIDTH = 17
);
    logic                 wr_valid;
    logic                 wr_ready;
    logic [CHW-1:0]       wr_chan;
    logic [CNT_WIDTH-1:0] wr_duty;
    modport master (output wr_valid, wr_chan, wr_duty, input wr_ready);
    modport slave  (input wr_valid, wr_chan, wr_duty, output wr_ready);
endinterface

// File: rtl/pwm_multi.sv
// pwm_multi: shared-counter multi-channel PWM with double-buffered duty and optional phase stagger
module pwm_multi #(
    parameter int CHANNELS  = 4,
    parameter int CNT_WIDTH = 17,
    parameter int PERIOD    = 100000,
    parameter int STAGGER   = 0
) (
    input  logic                clock_50mhz,
    input  logic                reset_n,
    input  logic                enable,
    pwm_multi_if.slave          wr,
    input  logic [CHANNELS-1:0] invert,
    output logic [CHANNELS-1:0] pwm,
    output logic                period_start
);
    localparam int CHW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    localparam int OFF = STAGGER != 0 ? PERIOD / CHANNELS : 0;
    localparam logic [CNT_WIDTH:0]   P    = (CNT_WIDTH+1)'(PERIOD);
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(PERIOD - 1);
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] act  [CHANNELS];
    logic [CNT_WIDTH-1:0] pend [CHANNELS];
    logic [CNT_WIDTH:0]   ph   [CHANNELS];
    logic [CHANNELS-1:0]  pf, raw, wrap, acc;
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        localparam logic [CNT_WIDTH:0] O = (CNT_WIDTH+1)'(i * OFF);
        logic [CNT_WIDTH:0] s;
        assign s       = {1'b0, cnt} + O;
        assign ph[i]   = s >= P ? s - P : s;
        assign raw[i]  = ph[i] < {1'b0, act[i]};
        assign wrap[i] = ph[i] == {1'b0, LAST};
        assign acc[i]  = wr.wr_valid && wr.wr_ready && wr.wr_chan == CHW'(i);
    end
    // out-of-range channels never match, so they stay ready and writes vanish
    always_comb begin
        wr.wr_ready = 1'b1;
        for (int i = 0; i < CHANNELS; i++)
            if (wr.wr_chan == CHW'(i)) wr.wr_ready = !pf[i];
    end
    always_ff @(posedge clock_50mhz) begin
        if (!reset_n) begin
            cnt          <= '0;
            period_start <= 1'b0;
        end else begin
            period_start <= enable && cnt == LAST;
            cnt          <= (!enable || cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end
    always_ff @(posedge clock_50mhz) begin
        if (!reset_n) begin
            pwm <= '0;
            pf  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                act[i]  <= '0;
                pend[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                pwm[i] <= enable ? raw[i] ^ invert[i] : invert[i];
                if (pf[i] && (!enable || wrap[i])) begin
                    act[i] <= pend[i];
                    pf[i]  <= 1'b0;
                end else if (acc[i]) begin
                    pend[i] <= wr.wr_duty;
                    pf[i]   <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed + random checks of unstaggered and staggered instances against a spec-level model
module tb_pwm_multi;
    localparam int C = 4, W = 4, P = 10, CHW = 2;
    logic clock_50mhz = 1'b0;
    logic reset_n = 1'b0, enable = 1'b0;
    logic [C-1:0] invert = '0;
    logic [C-1:0] pwm0, pwm1;
    logic ps0, ps1;
    logic wv = 1'b0;
    logic [CHW-1:0] wc = '0;
    logic [W-1:0] wd = '0;
    int tests = 0, fails = 0;
    int m_cnt [2];
    int m_act [2][C];
    int m_pend [2][C];
    bit m_pf [2][C];
    bit [C-1:0] m_pwm [2];
    bit m_ps [2];

    always #5 clock_50mhz = ~clock_50mhz;

    pwm_multi_if #(.CHW(CHW), .CNT_WIDTH(W)) w0 ();
    pwm_multi_if #(.CHW(CHW), .CNT_WIDTH(W)) w1 ();
    assign w0.wr_valid = wv;
    assign w0.wr_chan  = wc;
    assign w0.wr_duty  = wd;
    assign w1.wr_valid = wv;
    assign w1.wr_chan  = wc;
    assign w1.wr_duty  = wd;

    pwm_multi #(.CHANNELS(C), .CNT_WIDTH(W), .PERIOD(P), .STAGGER(0)) u0 (
        .clock_50mhz(clock_50mhz), .reset_n(reset_n), .enable(enable), .wr(w0.slave),
        .invert(invert), .pwm(pwm0), .period_start(ps0));
    pwm_multi #(.CHANNELS(C), .CNT_WIDTH(W), .PERIOD(P), .STAGGER(1)) u1 (
        .clock_50mhz(clock_50mhz), .reset_n(reset_n), .enable(enable), .wr(w1.slave),
        .invert(invert), .pwm(pwm1), .period_start(ps1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // one clock: check ready before the edge, advance the model, check registered outputs after
    task automatic step();
        int n_cnt [2];
        int n_act [2][C];
        int n_pend [2][C];
        bit n_pf [2][C];
        bit [C-1:0] n_pwm [2];
        bit n_ps [2];
        #1;
        chk("ready0", w0.wr_ready, !m_pf[0][wc]);
        chk("ready1", w1.wr_ready, !m_pf[1][wc]);
        for (int k = 0; k < 2; k++) begin
            int off;
            off = k ? P / C : 0;
            n_ps[k]  = reset_n && enable && m_cnt[k] == P - 1;
            n_cnt[k] = (reset_n && enable) ? (m_cnt[k] + 1) % P : 0;
            for (int i = 0; i < C; i++) begin
                int ph;
                ph = (m_cnt[k] + i * off) % P;
                n_act[k][i]  = m_act[k][i];
                n_pend[k][i] = m_pend[k][i];
                n_pf[k][i]   = m_pf[k][i];
                n_pwm[k][i]  = enable ? ((ph < m_act[k][i]) ^ invert[i]) : invert[i];
                if (m_pf[k][i] && (!enable || ph == P - 1)) begin
                    n_act[k][i] = m_pend[k][i];
                    n_pf[k][i]  = 1'b0;
                end else if (wv && wc == i && !m_pf[k][i]) begin
                    n_pend[k][i] = wd;
                    n_pf[k][i]   = 1'b1;
                end
                if (!reset_n) begin
                    n_act[k][i]  = 0;
                    n_pend[k][i] = 0;
                    n_pf[k][i]   = 1'b0;
                    n_pwm[k][i]  = 1'b0;
                end
            end
        end
        @(posedge clock_50mhz);
        #1;
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = n_cnt[k];
            m_ps[k]  = n_ps[k];
            m_pwm[k] = n_pwm[k];
            for (int i = 0; i < C; i++) begin
                m_act[k][i]  = n_act[k][i];
                m_pend[k][i] = n_pend[k][i];
                m_pf[k][i]   = n_pf[k][i];
            end
        end
        chk("pwm0", pwm0, m_pwm[0]);
        chk("pwm1", pwm1, m_pwm[1]);
        chk("pstart0", ps0, m_ps[0]);
        chk("pstart1", ps1, m_ps[1]);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wr(input int chan, input int duty);
        bit d0, d1;
        int n;
        d0 = 0; d1 = 0; n = 0;
        wv = 1'b1; wc = CHW'(chan); wd = W'(duty);
        while (!(d0 && d1) && n < 3 * P + 5) begin
            bit a0, a1;
            a0 = !m_pf[0][chan];
            a1 = !m_pf[1][chan];
            step();
            d0 |= a0; d1 |= a1; n++;
        end
        chk("wr_accept", d0 && d1, 1);
        wv = 1'b0;
    endtask

    // step until the output in view reflects phase 0 of channel 0
    task automatic align();
        int n;
        n = 0;
        while (m_cnt[0] != 1 && n < 2 * P) begin step(); n++; end
        chk("align", m_cnt[0], 1);
    endtask

    task automatic count_high(input string tag, input int exp);
        int hi, ps;
        hi = pwm0[0]; ps = ps0;
        repeat (P - 1) begin step(); hi += pwm0[0]; ps += ps0; end
        chk(tag, hi, exp);
        chk("pstart_per_period", ps, 1);
    endtask

    initial begin
        int r [C];
        logic [C-1:0] prev;
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_ps[k] = 0; m_pwm[k] = '0;
            for (int i = 0; i < C; i++) begin m_act[k][i] = 0; m_pend[k][i] = 0; m_pf[k][i] = 0; end
        end
        run(3);
        chk("rst_pwm", pwm0, 0);
        chk("rst_ready", w0.wr_ready, 1);
        reset_n = 1'b1;
        wr(0, 3);
        enable = 1'b1;
        run(12);
        align();
        count_high("duty3_high", 3);
        wr(1, 0);
        wr(2, 15);
        run(2 * P + 2);
        chk("duty0_low", pwm0[1], 0);
        chk("duty15_high", pwm0[2], 1);
        invert = 4'b0110;
        run(3);
        chk("inv_duty0", pwm0[1], 1);
        chk("inv_duty15", pwm0[2], 0);
        invert = '0;
        run(4);
        wr(0, 7);
        chk("ready_after_accept", w0.wr_ready, 0);
        wr(0, 5);
        align();
        count_high("duty7_high", 7);
        step();
        align();
        count_high("duty5_high", 5);
        enable = 1'b0;
        step();
        for (int i = 0; i < C; i++) wr(i, 5);
        enable = 1'b1;
        prev = pwm1;
        for (int i = 0; i < C; i++) r[i] = -1;
        for (int s = 0; s < 25; s++) begin
            step();
            for (int i = 0; i < C; i++)
                if (s >= 3 && r[i] < 0 && !prev[i] && pwm1[i]) r[i] = s;
            prev = pwm1;
        end
        for (int i = 1; i < C; i++)
            chk($sformatf("stagger%0d", i), ((r[0] - r[i]) % P + P) % P, 2 * i);
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 5) == 0) enable = ~enable;
            if ($urandom_range(0, 7) == 0) invert = C'($urandom);
            wr($urandom_range(0, C - 1), $urandom_range(0, (1 << W) - 1));
            run($urandom_range(0, 12));
        end
        enable = 1'b0; invert = 4'b1010;
        run(3);
        enable = 1'b1;
        run(4);
        wv = 1'b1; wc = 2'd3; wd = 4'd9;
        step();
        wv = 1'b0;
        step();
        chk("pend_ready", w0.wr_ready, 0);
        enable = 1'b0;
        step();
        chk("en_off_pwm", pwm0, 4'b1010);
        chk("en_off_loaded", w0.wr_ready, 1);
        enable = 1'b1;
        run(P + 2);
        enable = 1'b1; invert = '0;
        run(5);
        wv = 1'b1; wc = 2'd2; wd = 4'd4;
        step();
        wv = 1'b0;
        reset_n = 1'b0;
        step();
        chk("midrst_pwm", pwm0, 0);
        chk("midrst_pstart", ps0, 0);
        chk("midrst_ready", w0.wr_ready, 1);
        reset_n = 1'b1;
        run(P + 5);
        chk("post_rst_act0", pwm0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
